branch_predictor_param: RTL and testbench

- Parametrised dynamic conditional-branch predictor for the 5-stage MIPS pipeline. Generalises the fixed predictor used today.
- Configurable table depth, counter width and global-history length.
- Two modes: bimodal (PC-indexed) or gshare (PC XOR history).
- Looks up in F, presents the prediction in D, updates from the resolved outcome in M.
- Keeps a speculative global history with mispredict repair, a reset-time table-initialisation sweep, and performance counters.

---
 rtl/branch_predictor_param_if.sv | 42 ++++
 rtl/branch_predictor_param.sv | 176 +++++++++++++++++
 tb/tb_branch_predictor_param.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_param_if.sv
// Bundle of the fetch/decode lookup signals and memory-stage resolution
// signals of the branch predictor. The predictor sits on the slave modport.
//
// Handshake: there is no valid/ready flow control on the pipeline side.
// Every cycle is a transfer, and the pipeline qualifies it with branchD /
// branchM and the stall/flush strobes. "ready" is a level status: while it
// is low the table is still initialising. During that time predictions
// read as not-taken and resolved branches are dropped.
interface branch_predictor_param_if #(
    parameter int IDX_W = 10,
    parameter int GHR_W = 8
);
    logic [31:0]      pcF;
    logic             stallD;
    logic             flushD;
    logic             branchD;
    logic             pred_takeD;
    logic [IDX_W-1:0] idxD;
    logic [GHR_W-1:0] ghrD;
    logic             stallM;
    logic             branchM;
    logic             pred_takeM;
    logic             actual_takeM;
    logic [IDX_W-1:0] idxM;
    logic [GHR_W-1:0] ghrM;
    logic             ready;
    logic [31:0]      branch_cnt;
    logic [31:0]      mispred_cnt;
    logic             state_dbg;

    modport master (
        output pcF, stallD, flushD, branchD,
        output stallM, branchM, pred_takeM, actual_takeM, idxM, ghrM,
        input  pred_takeD, idxD, ghrD, ready, branch_cnt, mispred_cnt, state_dbg
    );

    modport slave (
        input  pcF, stallD, flushD, branchD,
        input  stallM, branchM, pred_takeM, actual_takeM, idxM, ghrM,
        output pred_takeD, idxD, ghrD, ready, branch_cnt, mispred_cnt, state_dbg
    );
endinterface

// File: rtl/branch_predictor_param.sv
// Parametrised bimodal/gshare conditional-branch predictor.
// The table is looked up in F and the result is registered into D.
// The table is updated from the resolved outcome in M.
// A speculative global history is kept and repaired on a mispredict.
// After reset, an INIT sweep writes weakly-not-taken into every entry.
module branch_predictor_param #(
    parameter int PHT_DEPTH = 1024,
    parameter int CTR_WIDTH = 2,
    parameter int GHR_WIDTH = 8,
    parameter int MODE      = 1
) (
    input logic                     clk,
    input logic                     rst,
    branch_predictor_param_if.slave bus
);
    localparam int IDX = $clog2(PHT_DEPTH);
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};
    localparam logic [IDX-1:0]       PTR_LAST = IDX'(PHT_DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [IDX-1:0]       ptr_q, ptr_d;
    logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
    logic [IDX-1:0]       idxd_q, idxd_d;
    logic [GHR_WIDTH-1:0] ghrd_q, ghrd_d;
    logic [CTR_WIDTH-1:0] ctrd_q, ctrd_d;
    logic [31:0]          branch_cnt_q, branch_cnt_d;
    logic [31:0]          mispred_cnt_q, mispred_cnt_d;

    logic [CTR_WIDTH-1:0] pht [PHT_DEPTH];

    logic                 ready;
    logic                 upd;
    logic                 mispred;
    logic                 pred_take;
    logic                 d_shift;
    logic [IDX-1:0]       pc_idx;
    logic [IDX-1:0]       idx_f;
    logic [CTR_WIDTH-1:0] ctr_old;
    logic [CTR_WIDTH-1:0] ctr_new;
    logic                 pht_we;
    logic [IDX-1:0]       pht_waddr;
    logic [CTR_WIDTH-1:0] pht_wdata;
    logic                 unused_pc_bits;

    assign ready          = (state_q == ST_RUN);
    assign pc_idx         = bus.pcF[IDX+1:2];
    assign unused_pc_bits = ^{bus.pcF[31:IDX+2], bus.pcF[1:0]};
    assign pred_take      = bus.branchD & ready & ctrd_q[CTR_WIDTH-1];
    assign d_shift        = bus.branchD & ~bus.stallD & ~bus.flushD & ready;
    assign upd            = ready & bus.branchM & ~bus.stallM;
    assign mispred        = upd & (bus.pred_takeM != bus.actual_takeM);

    // FSM next state: sweep one entry per cycle, then stay in RUN for good
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_INIT: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
            end
        endcase
    end

    // Fetch index: PC word index, optionally hashed with speculative history
    always_comb begin
        idx_f = pc_idx;
        if (MODE != 0) begin
            idx_f = pc_idx ^ IDX'(ghr_q);
        end
    end

    // Saturating counter step and the single table write port (init or update)
    always_comb begin
        ctr_old = pht[bus.idxM];
        ctr_new = ctr_old;
        if (bus.actual_takeM) begin
            if (ctr_old != CTR_MAX) ctr_new = ctr_old + 1'b1;
        end else begin
            if (ctr_old != '0) ctr_new = ctr_old - 1'b1;
        end
        pht_we    = 1'b0;
        pht_waddr = bus.idxM;
        pht_wdata = ctr_new;
        if (state_q == ST_INIT) begin
            pht_we    = rst;
            pht_waddr = ptr_q;
            pht_wdata = CTR_INIT;
        end else if (upd) begin
            pht_we = rst;
        end
    end

    // Speculative history: a repair from M beats a shift from D
    always_comb begin
        ghr_d = ghr_q;
        if (!ready) begin
            ghr_d = '0;
        end else if (mispred) begin
            ghr_d = (bus.ghrM << 1) | GHR_WIDTH'(bus.actual_takeM);
        end else if (d_shift) begin
            ghr_d = (ghr_q << 1) | GHR_WIDTH'(pred_take);
        end
    end

    // D-stage registers: flush clears, stall holds, else capture the lookup.
    // The table read sees the value from before any same-edge write.
    always_comb begin
        idxd_d = idx_f;
        ghrd_d = ghr_q;
        ctrd_d = pht[idx_f];
        if (bus.flushD) begin
            idxd_d = '0;
            ghrd_d = '0;
            ctrd_d = '0;
        end else if (bus.stallD) begin
            idxd_d = idxd_q;
            ghrd_d = ghrd_q;
            ctrd_d = ctrd_q;
        end
    end

    // Performance counters, free-running and wrapping
    always_comb begin
        branch_cnt_d  = branch_cnt_q + {31'b0, upd};
        mispred_cnt_d = mispred_cnt_q + {31'b0, mispred};
    end

    // State register for FSM, history, D stage and counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_INIT;
            ptr_q         <= '0;
            ghr_q         <= '0;
            idxd_q        <= '0;
            ghrd_q        <= '0;
            ctrd_q        <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            ghr_q         <= ghr_d;
            idxd_q        <= idxd_d;
            ghrd_q        <= ghrd_d;
            ctrd_q        <= ctrd_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    // Pattern history table write
    always_ff @(posedge clk) begin
        if (pht_we) begin
            pht[pht_waddr] <= pht_wdata;
        end
    end

    assign bus.pred_takeD  = pred_take;
    assign bus.idxD        = idxd_q;
    assign bus.ghrD        = ghrd_q;
    assign bus.ready       = ready;
    assign bus.branch_cnt  = branch_cnt_q;
    assign bus.mispred_cnt = mispred_cnt_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_branch_predictor_param.sv
// Directed bench for branch_predictor_param.
// dut_b is a 16-entry bimodal instance; dut_g is a 256-entry gshare instance
// with 8-bit history.
module tb_branch_predictor_param;
    logic clk;
    logic rst_b;
    logic rst_g;
    int   checks;
    int   errors;

    branch_predictor_param_if #(.IDX_W(4), .GHR_W(4)) bif ();
    branch_predictor_param_if #(.IDX_W(8), .GHR_W(8)) gif ();

    branch_predictor_param #(
        .PHT_DEPTH(16), .CTR_WIDTH(2), .GHR_WIDTH(4), .MODE(0)
    ) dut_b (
        .clk(clk), .rst(rst_b), .bus(bif.slave)
    );

    branch_predictor_param #(
        .PHT_DEPTH(256), .CTR_WIDTH(2), .GHR_WIDTH(8), .MODE(1)
    ) dut_g (
        .clk(clk), .rst(rst_g), .bus(gif.slave)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        bd;
        logic        bm;
        logic        sm;
        logic        pm;
        logic        am;
        logic [7:0]  im;
        logic [7:0]  gm;
        logic        ep;
        logic [7:0]  eidx;
        logic [7:0]  eghr;
        logic        cg;
        logic [31:0] eb;
        logic [31:0] em;
    } vec_t;

    vec_t vb[$];
    vec_t vg[$];

    function automatic vec_t mv(input logic [31:0] pc, input logic bd, input logic bm,
                                input logic sm, input logic pm, input logic am,
                                input logic [7:0] im, input logic [7:0] gm, input logic ep,
                                input logic [7:0] eidx, input logic [7:0] eghr, input logic cg,
                                input logic [31:0] eb, input logic [31:0] em);
        vec_t v;
        v.pc = pc; v.bd = bd; v.bm = bm; v.sm = sm; v.pm = pm; v.am = am;
        v.im = im; v.gm = gm; v.ep = ep; v.eidx = eidx; v.eghr = eghr; v.cg = cg;
        v.eb = eb; v.em = em;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit g, input logic [31:0] pc, input logic bd, input logic sd,
                         input logic fd, input logic bm, input logic sm, input logic pm,
                         input logic am, input logic [7:0] im, input logic [7:0] gm);
        if (g) begin
            gif.pcF = pc; gif.branchD = bd; gif.stallD = sd; gif.flushD = fd;
            gif.branchM = bm; gif.stallM = sm; gif.pred_takeM = pm; gif.actual_takeM = am;
            gif.idxM = im; gif.ghrM = gm;
        end else begin
            bif.pcF = pc; bif.branchD = bd; bif.stallD = sd; bif.flushD = fd;
            bif.branchM = bm; bif.stallM = sm; bif.pred_takeM = pm; bif.actual_takeM = am;
            bif.idxM = im[3:0]; bif.ghrM = gm[3:0];
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input bit g, input string tag, input logic ep, input logic [7:0] eidx,
                             input logic [7:0] eghr, input logic cg,
                             input logic [31:0] eb, input logic [31:0] em);
        logic        p;
        logic [7:0]  idx;
        logic [7:0]  gh;
        logic [31:0] b;
        logic [31:0] m;
        if (g) begin
            p = gif.pred_takeD; idx = gif.idxD; gh = gif.ghrD;
            b = gif.branch_cnt; m = gif.mispred_cnt;
        end else begin
            p = bif.pred_takeD; idx = {4'b0, bif.idxD}; gh = {4'b0, bif.ghrD};
            b = bif.branch_cnt; m = bif.mispred_cnt;
        end
        chk({tag, " pred_takeD"}, {31'b0, p}, {31'b0, ep});
        chk({tag, " idxD"}, {24'b0, idx}, {24'b0, eidx});
        if (cg) chk({tag, " ghrD"}, {24'b0, gh}, {24'b0, eghr});
        chk({tag, " branch_cnt"}, b, eb);
        chk({tag, " mispred_cnt"}, m, em);
    endtask

    // Count edges until ready rises; prediction must stay low during the sweep
    task automatic wait_ready(input bit g, input int exp_cycles);
        int   n;
        logic r;
        n = 0;
        r = 1'b0;
        while (!r && n < exp_cycles + 50) begin
            tick;
            n++;
            r = g ? gif.ready : bif.ready;
            if (!r) chk("init pred_takeD", {31'b0, (g ? gif.pred_takeD : bif.pred_takeD)}, 32'd0);
        end
        chk("ready latency", n, exp_cycles);
        chk("state_dbg run", {31'b0, (g ? gif.state_dbg : bif.state_dbg)}, 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Bimodal table: {pc, bD, bM, sM, pM, aM, iM, gM, exp pred, idx, ghr, chk_ghr, bcnt, mcnt}
        vb.push_back(mv(32'h00400020, 1, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0));
        vb.push_back(mv(32'h0, 0, 1, 0, 0, 1, 8, 0, 0, 0, 0, 0, 1, 1));
        vb.push_back(mv(32'h4, 0, 1, 0, 1, 1, 8, 0, 0, 1, 0, 0, 2, 1));
        vb.push_back(mv(32'h00400020, 1, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0, 2, 1));
        vb.push_back(mv(32'h00400020, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 2, 1));
        for (int k = 0; k < 5; k++)
            vb.push_back(mv(32'h8, 0, 1, 0, 1, 1, 3, 0, 0, 2, 0, 0, 32'(3 + k), 1));
        vb.push_back(mv(32'hC, 1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 7, 1));
        vb.push_back(mv(32'h8, 0, 1, 0, 1, 0, 3, 0, 0, 2, 0, 0, 8, 2));
        vb.push_back(mv(32'hC, 1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 8, 2));
        for (int k = 0; k < 4; k++)
            vb.push_back(mv(32'h8, 0, 1, 0, 0, 0, 3, 0, 0, 2, 0, 0, 32'(9 + k), 2));
        vb.push_back(mv(32'hC, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 12, 2));
        vb.push_back(mv(32'h8, 0, 1, 0, 0, 1, 3, 0, 0, 2, 0, 0, 13, 3));
        vb.push_back(mv(32'hC, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 13, 3));
        vb.push_back(mv(32'h8, 0, 1, 0, 0, 1, 3, 0, 0, 2, 0, 0, 14, 4));
        vb.push_back(mv(32'hC, 1, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 14, 4));
        vb.push_back(mv(32'h14, 1, 1, 0, 0, 1, 5, 0, 0, 5, 0, 0, 15, 5));
        vb.push_back(mv(32'h14, 1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 15, 5));
        vb.push_back(mv(32'hFFFFFFFC, 1, 0, 0, 0, 0, 0, 0, 0, 15, 0, 0, 15, 5));
        vb.push_back(mv(32'h3C, 0, 1, 1, 0, 1, 15, 0, 0, 15, 0, 0, 15, 5));

        // Gshare table: history repair, speculative shifts, hashed index
        vg.push_back(mv(32'h40, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h10, 8'h00, 1, 0, 0));
        vg.push_back(mv(32'h40, 0, 1, 0, 0, 1, 8'h10, 8'h2A, 0, 8'h10, 8'h00, 1, 1, 1));
        vg.push_back(mv(32'h40, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h45, 8'h55, 1, 1, 1));
        vg.push_back(mv(32'h40, 1, 1, 0, 0, 1, 8'h45, 8'h55, 0, 8'hBA, 8'hAA, 1, 2, 2));
        vg.push_back(mv(32'h40, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'hBB, 8'hAB, 1, 2, 2));
        vg.push_back(mv(32'h40, 0, 1, 0, 1, 1, 8'h20, 8'h00, 0, 8'hBB, 8'hAB, 1, 3, 2));
        vg.push_back(mv(32'h40, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'hBB, 8'hAB, 1, 3, 2));
        vg.push_back(mv(32'h3B8, 1, 0, 0, 0, 0, 8'h00, 8'h00, 1, 8'h45, 8'hAB, 1, 3, 2));
        vg.push_back(mv(32'h40, 1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'h46, 8'h56, 1, 3, 2));
        vg.push_back(mv(32'h40, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 8'hBD, 8'hAD, 1, 3, 2));

        // Reset both instances and check the reset state
        rst_b = 1'b0;
        rst_g = 1'b0;
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick;
        chk("reset b ready", {31'b0, bif.ready}, 32'd0);
        chk("reset b state_dbg", {31'b0, bif.state_dbg}, 32'd0);
        check_out(0, "reset b", 0, 0, 0, 1, 0, 0);
        chk("reset g ready", {31'b0, gif.ready}, 32'd0);
        check_out(1, "reset g", 0, 0, 0, 1, 0, 0);

        // Bimodal: sweep with branchD high and M updates that must be ignored
        rst_b = 1'b1;
        drive(0, 32'h8, 1, 0, 0, 1, 0, 0, 1, 8, 0);
        wait_ready(0, 16);
        chk("b cnt after init", bif.branch_cnt, 32'd0);
        chk("b mcnt after init", bif.mispred_cnt, 32'd0);

        foreach (vb[i]) begin
            drive(0, vb[i].pc, vb[i].bd, 0, 0, vb[i].bm, vb[i].sm, vb[i].pm, vb[i].am,
                  vb[i].im, vb[i].gm);
            tick;
            check_out(0, $sformatf("b row %0d", i), vb[i].ep, vb[i].eidx, vb[i].eghr,
                      vb[i].cg, vb[i].eb, vb[i].em);
        end

        // stallD holds the D registers for three cycles
        drive(0, 32'h14, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        check_out(0, "stallD pre", 1, 5, 0, 0, 15, 5);
        for (int k = 0; k < 3; k++) begin
            drive(0, 32'h0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
            tick;
            check_out(0, $sformatf("stallD hold %0d", k), 1, 5, 0, 0, 15, 5);
        end
        drive(0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        check_out(0, "stallD release", 0, 0, 0, 0, 15, 5);

        // flushD wins over stallD and clears the D registers
        drive(0, 32'h14, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        drive(0, 32'h14, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        tick;
        check_out(0, "flushD", 0, 0, 0, 0, 15, 5);
        drive(0, 32'h14, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        check_out(0, "after flushD", 1, 5, 0, 0, 15, 5);

        // stallM: one update after four stalled cycles
        for (int k = 0; k < 4; k++) begin
            drive(0, 32'h0, 0, 0, 0, 1, 1, 1, 1, 6, 0);
            tick;
            chk($sformatf("stallM cnt %0d", k), bif.branch_cnt, 32'd15);
        end
        drive(0, 32'h0, 0, 0, 0, 1, 0, 1, 1, 6, 0);
        tick;
        chk("stallM release cnt", bif.branch_cnt, 32'd16);
        drive(0, 32'h0, 0, 0, 0, 1, 0, 1, 0, 6, 0);
        tick;
        check_out(0, "idx6 nt", 0, 0, 0, 0, 17, 6);
        drive(0, 32'h18, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        check_out(0, "idx6 lookup", 0, 6, 0, 0, 17, 6);

        // Reset mid-run restarts the sweep
        rst_b = 1'b0;
        drive(0, 32'h14, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        chk("midrun rst ready", {31'b0, bif.ready}, 32'd0);
        chk("midrun rst state_dbg", {31'b0, bif.state_dbg}, 32'd0);
        check_out(0, "midrun rst", 0, 0, 0, 1, 0, 0);
        rst_b = 1'b1;
        drive(0, 32'h14, 1, 0, 0, 1, 0, 0, 1, 0, 0);
        wait_ready(0, 16);
        chk("re-init cnt", bif.branch_cnt, 32'd0);

        // Every entry reads exactly 1: not-taken now, taken after one increment
        for (int i = 0; i < 16; i++) begin
            drive(0, 32'(i * 4), 1, 0, 0, 0, 0, 0, 0, 0, 0);
            tick;
            chk($sformatf("entry %0d init pred", i), {31'b0, bif.pred_takeD}, 32'd0);
        end
        for (int i = 0; i <= 16; i++) begin
            drive(0, (i > 0) ? 32'((i - 1) * 4) : 32'h0, (i > 0), 0, 0, (i < 16), 0, 0, 1,
                  8'(i), 0);
            tick;
            if (i > 0) begin
                chk($sformatf("entry %0d bumped pred", i - 1), {31'b0, bif.pred_takeD}, 32'd1);
                chk($sformatf("entry %0d idx", i - 1), {28'b0, bif.idxD}, 32'(i - 1));
            end
        end
        chk("sweep branch_cnt", bif.branch_cnt, 32'd16);
        chk("sweep mispred_cnt", bif.mispred_cnt, 32'd16);

        // Gshare instance
        rst_g = 1'b1;
        drive(1, 32'h40, 1, 0, 0, 1, 0, 0, 1, 8'h10, 8'hFF);
        wait_ready(1, 256);
        foreach (vg[i]) begin
            drive(1, vg[i].pc, vg[i].bd, 0, 0, vg[i].bm, vg[i].sm, vg[i].pm, vg[i].am,
                  vg[i].im, vg[i].gm);
            tick;
            check_out(1, $sformatf("g row %0d", i), vg[i].ep, vg[i].eidx, vg[i].eghr,
                      vg[i].cg, vg[i].eb, vg[i].em);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
